// File: rtl/multicycle_controller.sv
// ============================================================================
// multicycle_controller: Moore control FSM for a multicycle MIPS-style datapath
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic       ZERO,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output logic       pc_write,
  output logic       IR_write,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_dst,
  output logic       jal_reg,
  output logic       mem_to_reg,
  output logic       pc_to_reg,
  output logic       I_or_D,
  output logic       alu_src_A,
  output logic [1:0] alu_src_B,
  output logic [1:0] pc_src,
  output logic [2:0] alu_op
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_LW_WB     = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_I_EXEC    = 4'd9,
    S_I_WB      = 4'd10,
    S_JUMP      = 4'd11,
    S_JAL       = 4'd12,
    S_JR        = 4'd13
  } state_t;

  state_t     state_q, state_d;
  // ALU operation and branch sense are captured in DECODE so later states depend only on registers
  logic [2:0] exec_op_q, exec_op_d;
  logic       bne_q, bne_d;
  logic       is_lw_q, is_lw_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      exec_op_q <= ALU_ADD;
      bne_q     <= 1'b0;
      is_lw_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      exec_op_q <= exec_op_d;
      bne_q     <= bne_d;
      is_lw_q   <= is_lw_d;
    end
  end

  always_comb begin
    state_d    = S_FETCH;
    exec_op_d  = exec_op_q;
    bne_d      = bne_q;
    is_lw_d    = is_lw_q;
    pc_write   = 1'b0;
    IR_write   = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_dst    = 1'b0;
    jal_reg    = 1'b0;
    mem_to_reg = 1'b0;
    pc_to_reg  = 1'b0;
    I_or_D     = 1'b0;
    alu_src_A  = 1'b0;
    alu_src_B  = 2'b00;
    pc_src     = 2'b00;
    alu_op     = ALU_ADD;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        IR_write  = 1'b1;
        alu_src_B = 2'b01;
        pc_write  = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        alu_src_B = 2'b11;
        case (opcode)
          OP_R: begin
            state_d = S_R_EXEC;
            case (func)
              FN_ADD:  exec_op_d = ALU_ADD;
              FN_SUB:  exec_op_d = ALU_SUB;
              FN_AND:  exec_op_d = ALU_AND;
              FN_OR:   exec_op_d = ALU_OR;
              FN_SLT:  exec_op_d = ALU_SLT;
              FN_JR:   state_d   = S_JR;
              default: state_d   = S_FETCH;
            endcase
          end
          OP_LW:   begin state_d = S_MEM_ADDR; is_lw_d = 1'b1; end
          OP_SW:   begin state_d = S_MEM_ADDR; is_lw_d = 1'b0; end
          OP_ADDI: begin state_d = S_I_EXEC; exec_op_d = ALU_ADD; end
          OP_SLTI: begin state_d = S_I_EXEC; exec_op_d = ALU_SLT; end
          OP_ANDI: begin state_d = S_I_EXEC; exec_op_d = ALU_AND; end
          OP_BEQ:  begin state_d = S_BRANCH; bne_d = 1'b0; end
          OP_BNE:  begin state_d = S_BRANCH; bne_d = 1'b1; end
          OP_J:    state_d = S_JUMP;
          OP_JAL:  state_d = S_JAL;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_A = 1'b1;
        alu_src_B = 2'b10;
        state_d   = is_lw_q ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        I_or_D   = 1'b1;
        state_d  = S_LW_WB;
      end
      S_LW_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        I_or_D    = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_A = 1'b1;
        alu_op    = exec_op_q;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_A = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = 2'b11;
        pc_write  = ZERO ^ bne_q;
      end
      S_I_EXEC: begin
        alu_src_A = 1'b1;
        alu_src_B = 2'b10;
        alu_op    = exec_op_q;
        state_d   = S_I_WB;
      end
      S_I_WB: begin
        reg_write = 1'b1;
      end
      S_JUMP: begin
        pc_src   = 2'b01;
        pc_write = 1'b1;
      end
      S_JAL: begin
        pc_src    = 2'b01;
        pc_write  = 1'b1;
        reg_write = 1'b1;
        jal_reg   = 1'b1;
        pc_to_reg = 1'b1;
      end
      S_JR: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // Outputs are forced low for the whole reset window, not just after the state flop clears
    if (rst) begin
      pc_write   = 1'b0;
      IR_write   = 1'b0;
      reg_write  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_dst    = 1'b0;
      jal_reg    = 1'b0;
      mem_to_reg = 1'b0;
      pc_to_reg  = 1'b0;
      I_or_D     = 1'b0;
      alu_src_A  = 1'b0;
      alu_src_B  = 2'b00;
      pc_src     = 2'b00;
      alu_op     = ALU_ADD;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// tb_multicycle_controller: directed self-checking bench for the control FSM
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ZERO = 1'b0;
  logic [5:0] opcode = 6'b0;
  logic [5:0] func = 6'b0;
  logic       pc_write, IR_write, reg_write, mem_read, mem_write;
  logic       reg_dst, jal_reg, mem_to_reg, pc_to_reg, I_or_D, alu_src_A;
  logic [1:0] alu_src_B, pc_src;
  logic [2:0] alu_op;

  int total = 0;
  int bad = 0;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .ZERO(ZERO), .opcode(opcode), .func(func),
    .pc_write(pc_write), .IR_write(IR_write), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .reg_dst(reg_dst),
    .jal_reg(jal_reg), .mem_to_reg(mem_to_reg), .pc_to_reg(pc_to_reg),
    .I_or_D(I_or_D), .alu_src_A(alu_src_A), .alu_src_B(alu_src_B),
    .pc_src(pc_src), .alu_op(alu_op)
  );

  always #5 clk = ~clk;

  // {pc_write, IR_write, reg_write, mem_read, mem_write, reg_dst, jal_reg,
  //  mem_to_reg, pc_to_reg, I_or_D, alu_src_A, alu_src_B, pc_src, alu_op}
  logic [17:0] obs;
  assign obs = {pc_write, IR_write, reg_write, mem_read, mem_write, reg_dst, jal_reg,
                mem_to_reg, pc_to_reg, I_or_D, alu_src_A, alu_src_B, pc_src, alu_op};

  localparam logic [17:0] E_ZERO   = 18'h0;
  localparam logic [17:0] E_FETCH  = {1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,3'b000};
  localparam logic [17:0] E_DECODE = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,3'b000};
  localparam logic [17:0] E_MADDR  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,3'b000};
  localparam logic [17:0] E_MREAD  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,3'b000};
  localparam logic [17:0] E_LWWB   = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,3'b000};
  localparam logic [17:0] E_MWRITE = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,3'b000};
  localparam logic [17:0] E_RWB    = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,3'b000};
  localparam logic [17:0] E_IWB    = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,3'b000};
  localparam logic [17:0] E_JUMP   = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,3'b000};
  localparam logic [17:0] E_JAL    = {1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,2'b01,3'b000};
  localparam logic [17:0] E_JR     = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,3'b000};
  localparam logic [17:0] E_REXEC0 = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,3'b000};
  localparam logic [17:0] E_IEXEC0 = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,3'b000};
  localparam logic [17:0] E_BR_NT  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b11,3'b001};
  localparam logic [17:0] E_BR_T   = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b11,3'b001};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (obs !== E_ZERO) begin bad++; $display("FAIL reset_hold0: got %h want %h", obs, E_ZERO); end
    opcode = 6'b100011;
    tick();
    total++;
    if (obs !== E_ZERO) begin bad++; $display("FAIL reset_hold1: got %h want %h", obs, E_ZERO); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (obs !== E_FETCH) begin bad++; $display("FAIL reset_release: got %h want %h", obs, E_FETCH); end
    opcode = 6'b000010;
    tick();
    total++;
    if (obs !== E_DECODE) begin bad++; $display("FAIL reset_first_edge: got %h want %h", obs, E_DECODE); end
    tick();
    tick();
  endtask

  task automatic test_lw();
    logic [17:0] exp_seq [6] = '{E_FETCH, E_DECODE, E_MADDR, E_MREAD, E_LWWB, E_FETCH};
    opcode = 6'b100011;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (obs !== exp_seq[i]) begin bad++; $display("FAIL lw step %0d: got %h want %h", i, obs, exp_seq[i]); end
      if (i < 5) tick();
    end
  endtask

  task automatic test_sw();
    logic [17:0] exp_seq [5] = '{E_FETCH, E_DECODE, E_MADDR, E_MWRITE, E_FETCH};
    opcode = 6'b101011;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (obs !== exp_seq[i]) begin bad++; $display("FAIL sw step %0d: got %h want %h", i, obs, exp_seq[i]); end
      if (i < 4) tick();
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] op [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
    logic [17:0] exp_seq [5];
    opcode = 6'b000000;
    for (int k = 0; k < 5; k++) begin
      func = fn[k];
      exp_seq = '{E_FETCH, E_DECODE, E_REXEC0 | {15'b0, op[k]}, E_RWB, E_FETCH};
      for (int i = 0; i < 5; i++) begin
        total++;
        if (obs !== exp_seq[i]) begin bad++; $display("FAIL rtype fn%0d step %0d: got %h want %h", k, i, obs, exp_seq[i]); end
        if (i < 4) tick();
      end
    end
  endtask

  task automatic test_jr();
    logic [17:0] exp_seq [4] = '{E_FETCH, E_DECODE, E_JR, E_FETCH};
    opcode = 6'b000000;
    func   = 6'b001000;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs !== exp_seq[i]) begin bad++; $display("FAIL jr step %0d: got %h want %h", i, obs, exp_seq[i]); end
      if (i < 3) tick();
    end
  endtask

  task automatic test_itype();
    logic [5:0] opc [3] = '{6'b001000, 6'b001010, 6'b001100};
    logic [2:0] op  [3] = '{3'b000, 3'b100, 3'b010};
    logic [17:0] exp_seq [5];
    for (int k = 0; k < 3; k++) begin
      opcode = opc[k];
      exp_seq = '{E_FETCH, E_DECODE, E_IEXEC0 | {15'b0, op[k]}, E_IWB, E_FETCH};
      for (int i = 0; i < 5; i++) begin
        total++;
        if (obs !== exp_seq[i]) begin bad++; $display("FAIL itype op%0d step %0d: got %h want %h", k, i, obs, exp_seq[i]); end
        if (i < 4) tick();
      end
    end
  endtask

  task automatic test_branch();
    logic [5:0] opc [2] = '{6'b000100, 6'b000101};
    for (int k = 0; k < 2; k++) begin
      opcode = opc[k];
      ZERO = 1'b0;
      tick();
      total++;
      if (obs !== E_DECODE) begin bad++; $display("FAIL branch%0d decode: got %h want %h", k, obs, E_DECODE); end
      tick();
      ZERO = 1'b1;
      #1;
      total++;
      if (obs !== (k == 0 ? E_BR_T : E_BR_NT)) begin
        bad++; $display("FAIL branch%0d zero1: got %h want %h", k, obs, (k == 0 ? E_BR_T : E_BR_NT));
      end
      ZERO = 1'b0;
      #1;
      total++;
      if (obs !== (k == 0 ? E_BR_NT : E_BR_T)) begin
        bad++; $display("FAIL branch%0d zero0: got %h want %h", k, obs, (k == 0 ? E_BR_NT : E_BR_T));
      end
      tick();
      total++;
      if (obs !== E_FETCH) begin bad++; $display("FAIL branch%0d return: got %h want %h", k, obs, E_FETCH); end
    end
  endtask

  task automatic test_jumps();
    logic [17:0] exp_j   [4] = '{E_FETCH, E_DECODE, E_JUMP, E_FETCH};
    logic [17:0] exp_jal [4] = '{E_FETCH, E_DECODE, E_JAL, E_FETCH};
    opcode = 6'b000010;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs !== exp_j[i]) begin bad++; $display("FAIL j step %0d: got %h want %h", i, obs, exp_j[i]); end
      if (i < 3) tick();
    end
    opcode = 6'b000011;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs !== exp_jal[i]) begin bad++; $display("FAIL jal step %0d: got %h want %h", i, obs, exp_jal[i]); end
      if (i < 3) tick();
    end
  endtask

  task automatic test_illegal_op();
    logic [17:0] exp_seq [3] = '{E_FETCH, E_DECODE, E_FETCH};
    for (int k = 0; k < 2; k++) begin
      opcode = (k == 0) ? 6'b111111 : 6'b000000;
      func   = 6'b111111;
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs !== exp_seq[i] || reg_write !== 1'b0 || mem_write !== 1'b0) begin
          bad++; $display("FAIL illegal%0d step %0d: got %h want %h", k, i, obs, exp_seq[i]);
        end
        if (i < 2) tick();
      end
    end
  endtask

  task automatic test_reset_mid();
    opcode = 6'b100011;
    tick();
    tick();
    tick();
    total++;
    if (obs !== E_MREAD) begin bad++; $display("FAIL mid_pre: got %h want %h", obs, E_MREAD); end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (obs !== E_ZERO) begin bad++; $display("FAIL mid_async: got %h want %h", obs, E_ZERO); end
    tick();
    total++;
    if (obs !== E_ZERO) begin bad++; $display("FAIL mid_hold: got %h want %h", obs, E_ZERO); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (obs !== E_FETCH) begin bad++; $display("FAIL mid_release: got %h want %h", obs, E_FETCH); end
    opcode = 6'b101011;
    tick();
    total++;
    if (obs !== E_DECODE) begin bad++; $display("FAIL mid_decode: got %h want %h", obs, E_DECODE); end
    tick();
    tick();
    total++;
    if (obs !== E_MWRITE) begin bad++; $display("FAIL mid_sw: got %h want %h", obs, E_MWRITE); end
    tick();
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_jr();
    test_itype();
    test_branch();
    test_jumps();
    test_illegal_op();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 ZERO  input  1  ALU zero flag from datapath, combinational, same cycle.
REQ-004 opcode  input  6  IR[31:26].
REQ-005 func  input  6  IR[5:0].
REQ-006 pc_write, IR_write, reg_write, mem_read, mem_write  output  1 each  load/access enables.
REQ-007 reg_dst  output  1  0=rt, 1=rd; jal_reg  output  1  1=force r31.
REQ-008 mem_to_reg  output  1  0=AluOut, 1=MDR; pc_to_reg  output  1  1=write PC to register file.
REQ-009 I_or_D  output  1  0=PC, 1=AluOut memory address; alu_src_A  output  1  0=PC, 1=A.
REQ-010 alu_src_B  output  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
REQ-011 pc_src  output  2  00=ALU result, 01=jump target, 10=A (jr), 11=AluOut (branch target).
REQ-012 alu_op  output  3  000 add, 001 sub, 010 and, 011 or, 100 slt.

Function
REQ-013 Moore FSM, 4-bit state register; outputs decoded from state only, except pc_write in BRANCH (REQ-021); unlisted outputs are 0 in each state.
REQ-014 FETCH: mem_read=1, I_or_D=0, IR_write=1, alu_src_A=0, alu_src_B=01, alu_op=add, pc_src=00, pc_write=1 -> DECODE.
REQ-015 DECODE: alu_src_A=0, alu_src_B=11, alu_op=add (branch target into AluOut); next state by opcode.
REQ-016 Opcode map: 000000 R; 100011 lw; 101011 sw; 001000 addi; 001010 slti; 001100 andi; 000100 beq; 000101 bne; 000010 j; 000011 jal.
REQ-017 R-type func map: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt -> R_EXEC; 001000 -> JR.
REQ-018 Unknown opcode, or R-type with unknown func: DECODE -> FETCH; no register/memory write (NOP, PC already +4).
REQ-019 lw/sw -> MEM_ADDR (alu_src_A=1, alu_src_B=10, add); lw -> MEM_READ (mem_read=1, I_or_D=1) -> LW_WB (reg_write=1, reg_dst=0, mem_to_reg=1) -> FETCH; sw -> MEM_WRITE (mem_write=1, I_or_D=1) -> FETCH.
REQ-020 R_EXEC: alu_src_A=1, alu_src_B=00, alu_op per func -> R_WB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
REQ-021 BRANCH (beq/bne): alu_src_A=1, alu_src_B=00, alu_op=sub, pc_src=11; pc_write = ZERO for beq, ~ZERO for bne -> FETCH.
REQ-022 I_EXEC: alu_src_A=1, alu_src_B=10, alu_op add/slt/and for addi/slti/andi -> I_WB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
REQ-023 JUMP: pc_src=01, pc_write=1 -> FETCH.
REQ-024 JAL: pc_src=01, pc_write=1, reg_write=1, jal_reg=1, pc_to_reg=1 (r31 <= PC+4, same edge as PC update) -> FETCH.
REQ-025 JR: pc_src=10, pc_write=1 -> FETCH.
REQ-026 Cycle counts: j/jal/jr/beq/bne 3, sw 4, R/I-type 4, lw 5; one instruction in flight; no stalls.
REQ-027 Illegal state encodings -> FETCH next edge, all outputs 0 meanwhile.

Reset
REQ-028 rst=1 forces state=FETCH immediately, independent of clk.
REQ-029 While rst=1 every output is 0; first FETCH outputs assert after rst falls; first rising edge then loads IR.
REQ-030 rst mid-instruction abandons it; no further write enable from that instruction asserts.

Verification
REQ-031 Reset at arbitrary state -> all outputs 0 asynchronously; after release FETCH shows pc_write=1, IR_write=1, alu_src_B=01.
REQ-032 lw (100011) -> states FETCH, DECODE, MEM_ADDR, MEM_READ, LW_WB, FETCH; reg_write=1 only in LW_WB with mem_to_reg=1.
REQ-033 R-type func 101010 -> alu_op=100 in R_EXEC, reg_dst=1 and reg_write=1 in R_WB; func 001000 -> JR, pc_src=10, pc_write=1.
REQ-034 beq with ZERO=1 -> pc_write=1, pc_src=11; ZERO=0 -> pc_write=0; bne gives the inverse in both cases.
REQ-035 jal -> JAL state with jal_reg=1, pc_to_reg=1, reg_write=1, pc_write=1, pc_src=01 in one cycle.
REQ-036 opcode 111111 -> DECODE then FETCH; reg_write=0 and mem_write=0 throughout.
